// File: rtl/mdu_iter.sv
// mdu_iter - iterative multiply/divide unit for the RV64 execution stage.
//
// Handles every M-extension operation, including the 32-bit word forms,
// one operation at a time over a valid/ready handshake. Multiplies use a
// radix-2 shift-add over operand magnitudes; divides use restoring division
// producing one quotient bit per cycle. Divide-by-zero and signed overflow
// are resolved at accept time and bypass the iteration entirely.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      synchronous abort of the operation in progress
//   in_valid   request valid
//   in_ready   unit idle and able to accept (decoded from state only)
//   in_op      0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   in_word    word form select (ignored for MULH/MULHSU/MULHU)
//   in_src1    rs1: multiplicand / dividend
//   in_src2    rs2: multiplier / divisor
//   out_valid  registered result valid
//   out_ready  consumer accepts the result
//   out_result registered result, written only when entering DONE
module mdu_iter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_op,
  input  logic            in_word,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_FULL = CW'(XLEN - 1);
  localparam logic [CW-1:0] LAST_WORD = CW'(HALF - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              r_state;
  state_t              w_nextState;

  logic [2:0]          r_op;
  logic                r_word;
  logic                r_negQ;
  logic                r_negR;
  logic [CW-1:0]       r_cnt;
  logic                r_fin;
  logic [2*XLEN-1:0]   r_mcand;
  logic [XLEN-1:0]     r_mplr;
  logic [2*XLEN-1:0]   r_prod;
  logic [XLEN-1:0]     r_rem;
  logic [XLEN-1:0]     r_quo;
  logic [XLEN-1:0]     r_dvsr;

  logic                w_accept;
  logic                w_isDiv;
  logic                w_wordEff;
  logic                w_signedA;
  logic                w_signedB;
  logic [XLEN-1:0]     w_opA;
  logic [XLEN-1:0]     w_opB;
  logic                w_negA;
  logic                w_negB;
  logic [XLEN-1:0]     w_magA;
  logic [XLEN-1:0]     w_magB;
  logic [XLEN-1:0]     w_minVal;
  logic                w_divZero;
  logic                w_ovf;
  logic                w_special;
  logic [XLEN-1:0]     w_specRaw;
  logic [XLEN-1:0]     w_specialResult;
  logic [XLEN:0]       w_remShift;
  logic [XLEN:0]       w_diff;
  logic [2*XLEN-1:0]   w_prodS;
  logic [XLEN-1:0]     w_quoS;
  logic [XLEN-1:0]     w_remS;
  logic [XLEN-1:0]     w_rawResult;
  logic [XLEN-1:0]     w_finalResult;
  logic [CW-1:0]       w_lastCnt;

  // Sign-extend a half-width value to the full datapath.
  function automatic logic [XLEN-1:0] wordExt(input logic [HALF-1:0] v);
    return {{HALF{v[HALF-1]}}, v};
  endfunction

  assign in_ready = (r_state == IDLE);
  assign w_accept = in_valid & in_ready & ~flush;
  assign w_isDiv  = in_op[2];

  // The word flag only matters for MUL and the divide group.
  assign w_wordEff = in_word & ((in_op == 3'd0) | in_op[2]);

  // Unsigned treatment: MULHU, DIVU, REMU for both operands; MULHSU for rs2.
  assign w_signedA = ~((in_op == 3'd3) | (in_op == 3'd5) | (in_op == 3'd7));
  assign w_signedB = w_signedA & (in_op != 3'd2);

  // Operand extraction: word forms take the low half, sign- or zero-extended
  // according to the signedness of the operation.
  always_comb begin
    w_opA = in_src1;
    w_opB = in_src2;
    if (w_wordEff) begin
      w_opA = w_signedA ? wordExt(in_src1[HALF-1:0]) : {{HALF{1'b0}}, in_src1[HALF-1:0]};
      w_opB = w_signedA ? wordExt(in_src2[HALF-1:0]) : {{HALF{1'b0}}, in_src2[HALF-1:0]};
    end
  end

  assign w_negA = w_signedA & w_opA[XLEN-1];
  assign w_negB = w_signedB & w_opB[XLEN-1];
  assign w_magA = w_negA ? -w_opA : w_opA;
  assign w_magB = w_negB ? -w_opB : w_opB;

  // Most-negative value of the effective width, already sign-extended so it
  // compares directly against the extracted operand.
  assign w_minVal = w_wordEff ? {{HALF{1'b1}}, 1'b1, {(HALF-1){1'b0}}}
                              : {1'b1, {(XLEN-1){1'b0}}};

  assign w_divZero = w_isDiv & (w_opB == '0);
  assign w_ovf     = w_isDiv & ~in_op[0] & (w_opA == w_minVal) & (w_opB == '1);
  assign w_special = w_divZero | w_ovf;

  // in_op[1] separates the remainder ops (REM/REMU) from the quotient ops.
  always_comb begin
    w_specRaw = '0;
    if (w_divZero) begin
      w_specRaw = in_op[1] ? w_opA : '1;
    end else if (w_ovf) begin
      w_specRaw = in_op[1] ? '0 : w_opA;
    end
    w_specialResult = w_wordEff ? wordExt(w_specRaw[HALF-1:0]) : w_specRaw;
  end

  // Restoring divide step: bring the next dividend bit into the partial
  // remainder and keep the subtraction only when it does not go negative.
  assign w_remShift = {r_rem, r_quo[XLEN-1]};
  assign w_diff     = w_remShift - {1'b0, r_dvsr};
  assign w_lastCnt  = r_word ? LAST_WORD : LAST_FULL;

  // Result formation from the finished magnitudes; this runs in its own cycle
  // after the last iteration so the negation is off the iteration path.
  always_comb begin
    w_prodS = r_negQ ? -r_prod : r_prod;
    w_quoS  = r_negQ ? -r_quo : r_quo;
    w_remS  = r_negR ? -r_rem : r_rem;
    case (r_op)
      3'd0:              w_rawResult = w_prodS[XLEN-1:0];
      3'd1, 3'd2, 3'd3:  w_rawResult = w_prodS[2*XLEN-1:XLEN];
      3'd4, 3'd5:        w_rawResult = w_quoS;
      default:           w_rawResult = w_remS;
    endcase
    w_finalResult = r_word ? wordExt(w_rawResult[HALF-1:0]) : w_rawResult;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: special cases jump straight to DONE, normal operations
  // iterate in CALC; flush overrides everything, including out_ready.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_nextState = w_special ? DONE : CALC;
      CALC:    if (r_fin) w_nextState = DONE;
      DONE:    if (out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
    if (flush) w_nextState = IDLE;
  end

  // Datapath: load magnitudes on accept, then one multiply or divide step per
  // CALC cycle. Word divides pre-shift the dividend into the upper half so
  // that only HALF iterations are needed and the quotient lands in the low half.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op       <= '0;
      r_word     <= 1'b0;
      r_negQ     <= 1'b0;
      r_negR     <= 1'b0;
      r_cnt      <= '0;
      r_fin      <= 1'b0;
      r_mcand    <= '0;
      r_mplr     <= '0;
      r_prod     <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvsr     <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
    end else begin
      if (w_accept) begin
        r_op    <= in_op;
        r_word  <= w_wordEff;
        r_negQ  <= w_negA ^ w_negB;
        r_negR  <= w_negA;
        r_cnt   <= '0;
        r_fin   <= 1'b0;
        r_mcand <= {{XLEN{1'b0}}, w_magA};
        r_mplr  <= w_magB;
        r_prod  <= '0;
        r_rem   <= '0;
        r_quo   <= w_wordEff ? {w_magA[HALF-1:0], {HALF{1'b0}}} : w_magA;
        r_dvsr  <= w_magB;
      end else if ((r_state == CALC) && !r_fin) begin
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == w_lastCnt) r_fin <= 1'b1;
        if (r_op[2]) begin
          if (!w_diff[XLEN]) begin
            r_rem <= w_diff[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], 1'b1};
          end else begin
            r_rem <= w_remShift[XLEN-1:0];
            r_quo <= {r_quo[XLEN-2:0], 1'b0};
          end
        end else begin
          if (r_mplr[0]) r_prod <= r_prod + r_mcand;
          r_mcand <= {r_mcand[2*XLEN-2:0], 1'b0};
          r_mplr  <= {1'b0, r_mplr[XLEN-1:1]};
        end
      end

      if ((w_nextState == DONE) && (r_state != DONE)) begin
        out_result <= (r_state == IDLE) ? w_specialResult : w_finalResult;
      end
      out_valid <= (w_nextState == DONE);
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter - self-checking bench for mdu_iter (XLEN = 64).
//
// Directed and randomized operations are compared against a reference model
// that evaluates the M-extension rules with plain wide arithmetic. Latency,
// busy indication, backpressure hold, flush and asynchronous reset are
// checked alongside the results.
module tb_mdu_iter;

  localparam int XLEN = 64;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_op;
  logic            in_word;
  logic [XLEN-1:0] in_src1;
  logic [XLEN-1:0] in_src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;

  int nVectors = 0;
  int nMiss    = 0;

  mdu_iter #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_word    (in_word),
    .in_src1    (in_src1),
    .in_src2    (in_src2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  // Reference model: the architectural result of each operation, and whether
  // it is a divide-by-zero / overflow case that completes at the accept edge.
  function automatic logic [63:0] refModel(input logic [2:0] op, input logic word,
                                           input logic [63:0] a, input logic [63:0] b,
                                           output bit special);
    logic signed [127:0] sa128, sb128, ub128, sprod;
    logic [127:0]        uprod;
    logic [31:0]         p32;
    longint              sa, sb;
    longint unsigned     ua, ub;
    int                  sa32, sb32;
    int unsigned         ua32, ub32;
    bit                  isRem, isSigned;
    logic [63:0]         res;
    special  = 0;
    isRem    = op[1];
    isSigned = !op[0];
    sa = a;  sb = b;  ua = a;  ub = b;
    sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
    sa128 = {{64{a[63]}}, a};
    sb128 = {{64{b[63]}}, b};
    ub128 = {64'd0, b};
    res = '0;
    case (op)
      3'd0: begin
        p32 = a[31:0] * b[31:0];
        res = word ? sx32(p32) : a * b;
      end
      3'd1: begin sprod = sa128 * sb128; res = sprod[127:64]; end
      3'd2: begin sprod = sa128 * ub128; res = sprod[127:64]; end
      3'd3: begin uprod = {64'd0, a} * {64'd0, b}; res = uprod[127:64]; end
      default: begin
        if (word) begin
          if (ub32 == 0) begin
            special = 1;
            res = sx32(isRem ? a[31:0] : 32'hFFFF_FFFF);
          end else if (isSigned && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
            special = 1;
            res = sx32(isRem ? 32'd0 : a[31:0]);
          end else if (isSigned) begin
            res = sx32(isRem ? sa32 % sb32 : sa32 / sb32);
          end else begin
            res = sx32(isRem ? ua32 % ub32 : ua32 / ub32);
          end
        end else begin
          if (ub == 0) begin
            special = 1;
            res = isRem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
          end else if (isSigned && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
            special = 1;
            res = isRem ? 64'd0 : a;
          end else if (isSigned) begin
            res = isRem ? 64'(sa % sb) : 64'(sa / sb);
          end else begin
            res = isRem ? 64'(ua % ub) : 64'(ua / ub);
          end
        end
      end
    endcase
    return res;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nVectors++;
    assert (observed === expected) else begin
      nMiss++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One complete transaction: wait for idle, present the request, measure the
  // accept-to-valid latency, optionally withhold out_ready for 'hold' cycles,
  // then complete the handshake and confirm the unit is idle again.
  task automatic applyStimulus(input string tag, input logic [2:0] op, input logic word,
                               input logic [63:0] a, input logic [63:0] b, input int hold);
    logic [63:0] expRes, held;
    bit          special, leak, unstable;
    int          lat, expLat, guard;
    expRes = refModel(op, word, a, b, special);
    expLat = special ? 0 : ((word && (op == 3'd0 || op[2])) ? 33 : 65);
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput({tag, " ready"}, 64'(in_ready), 64'd1);
    in_op = op; in_word = word; in_src1 = a; in_src2 = b;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    leak = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) leak = 1;
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
    checkOutput({tag, " result"}, out_result, expRes);
    checkOutput({tag, " busy"}, 64'(leak), 64'd0);
    held = out_result;
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (out_result !== held || !out_valid || in_ready) unstable = 1;
    end
    if (hold > 0) checkOutput({tag, " hold"}, 64'(unstable), 64'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({tag, " release"}, {62'd0, in_ready, out_valid}, 64'd2);
  endtask

  initial begin
    logic [2:0]  rOp;
    logic        rWord;
    logic [63:0] rA, rB;
    int          sel, cnt;
    bit          rose;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_word = 1'b0; in_src1 = '0; in_src2 = '0;

    // Reset state.
    #12;
    checkOutput("reset in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset out_result", out_result, 64'd0);
    #1 rst = 1'b0;

    // Multiply group.
    applyStimulus("MUL 7*-3", 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 0);
    applyStimulus("MULHU ones", 3'd3, 1'b0, '1, '1, 0);
    applyStimulus("MULH ones", 3'd1, 1'b0, '1, '1, 0);
    applyStimulus("MULHSU ones", 3'd2, 1'b0, '1, '1, 0);

    // Divide group and special cases.
    applyStimulus("DIV -7/2", 3'd4, 1'b0, -64'sd7, 64'd2, 0);
    applyStimulus("REM -7/2", 3'd6, 1'b0, -64'sd7, 64'd2, 0);
    applyStimulus("DIVU x/0", 3'd5, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'd0, 0);
    applyStimulus("REMU 5/0", 3'd7, 1'b0, 64'd5, 64'd0, 0);
    applyStimulus("DIV ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 0);
    applyStimulus("REM ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 0);

    // Word forms.
    applyStimulus("DIVUW", 3'd5, 1'b1, 64'h1_FFFF_FFFF, 64'd1, 0);
    applyStimulus("MULW", 3'd0, 1'b1, 64'h8000_0000, 64'd1, 0);
    applyStimulus("REMW", 3'd6, 1'b1, 64'h1_0000_0007, 64'd2, 0);
    applyStimulus("DIVW ovf", 3'd4, 1'b1, 64'hABCD_0000_8000_0000, 64'h1234_5678_FFFF_FFFF, 0);

    // Backpressure followed by a back-to-back operation.
    applyStimulus("backpressure", 3'd4, 1'b0, 64'd1000, 64'd7, 5);
    applyStimulus("back-to-back", 3'd3, 1'b0, 64'hDEAD_BEEF_0123_4567, 64'hFEDC_BA98_7654_3210, 0);

    // Flush in the middle of CALC.
    in_op = 3'd4; in_word = 1'b0; in_src1 = 64'h7777_0000_1234_5678; in_src2 = 64'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush in_ready", 64'(in_ready), 64'd1);
    rose = 0;
    for (int i = 0; i < 80; i++) begin
      if (out_valid) rose = 1;
      @(posedge clk); #1;
    end
    checkOutput("flush no valid", 64'(rose), 64'd0);

    // Flush coinciding with a request blocks the accept.
    in_op = 3'd0; in_src1 = 64'd3; in_src2 = 64'd5;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checkOutput("flush blocks accept", 64'(in_ready), 64'd1);

    // Asynchronous reset pulse mid-CALC (previous result is nonzero).
    applyStimulus("pre-reset", 3'd5, 1'b0, 64'd99, 64'd4, 0);
    in_op = 3'd4; in_word = 1'b0; in_src1 = 64'd12345; in_src2 = 64'd11;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("async rst in_ready", 64'(in_ready), 64'd1);
    checkOutput("async rst out_valid", 64'(out_valid), 64'd0);
    checkOutput("async rst out_result", out_result, 64'd0);
    #1 rst = 1'b0;
    applyStimulus("post-reset", 3'd6, 1'b0, -64'sd100, 64'd7, 0);

    // Randomized operations with occasional special-case operands.
    for (int k = 0; k < 40; k++) begin
      rOp   = 3'($urandom_range(0, 7));
      rWord = 1'($urandom_range(0, 1));
      rA    = {$urandom, $urandom};
      rB    = {$urandom, $urandom};
      sel   = $urandom_range(0, 9);
      if (sel == 0) begin
        rB = rWord ? {$urandom, 32'd0} : 64'd0;
      end else if (sel == 1) begin
        rA = rWord ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
        rB = rWord ? {$urandom, 32'hFFFF_FFFF} : '1;
      end else if (sel == 2) begin
        rB = 64'($urandom_range(1, 5));
      end else if (sel == 3) begin
        rA = 64'($urandom_range(0, 50));
      end
      cnt = $urandom_range(0, 2);
      applyStimulus("random", rOp, rWord, rA, rB, cnt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
    $finish;
  end

endmodule
